// File: rtl/subneg_pkg.sv
// subneg_pkg
//   Shared definitions for the subtract-and-branch-if-negative core:
//   controller state encoding, default width/map constants, and the
//   branch-condition helper used in EXEC.
package subneg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_READ  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_MEM_DEPTH = 48;
  localparam int DEF_OUT_ADDR  = 63;
  localparam int DEF_IN_ADDR   = 62;

  // Unsigned mode branches on borrow (valA > valB); signed mode branches
  // when the wrapped difference has its sign bit set.
  function automatic logic branch_taken(input logic signed_cmp,
                                        input logic borrow,
                                        input logic res_msb);
    return signed_cmp ? res_msb : borrow;
  endfunction

endpackage

// File: rtl/subneg_mem.sv
// subneg_mem
//   MEM_DEPTH x DATA_W word array, no reset (contents survive core reset).
//   Ports:
//     clk                    clock, rising edge
//     i_rd_addr0..2          combinational read addresses
//     o_rd_data0..2          read data; 0 for addresses >= MEM_DEPTH
//     i_we/i_wr_addr/i_wr_data  synchronous write; out-of-range writes dropped
module subneg_mem
  import subneg_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_rd_addr0,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic [DATA_W-1:0] o_rd_data0,
  output logic [DATA_W-1:0] o_rd_data1,
  output logic [DATA_W-1:0] o_rd_data2,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
    if (int'(a) < MEM_DEPTH) return r_mem[a];
    return '0;
  endfunction

  assign o_rd_data0 = rd_word(i_rd_addr0);
  assign o_rd_data1 = rd_word(i_rd_addr1);
  assign o_rd_data2 = rd_word(i_rd_addr2);

  always_ff @(posedge clk) begin
    if (i_we && (int'(i_wr_addr) < MEM_DEPTH)) r_mem[i_wr_addr] <= i_wr_data;
  end

endmodule

// File: rtl/subneg_core_param.sv
// subneg_core_param
//   One-instruction core: mem[B] <= mem[B] - mem[A]; branch to C if the
//   result is "negative", else pc += 3. Three cycles per instruction
//   (FETCH, READ, EXEC), program load in IDLE, memory-mapped in/out words.
//   Optional build macro SUBNEG_STEP_EN adds the single-step input `step`.
//   Ports:
//     clk, rst_n          clock / async active-low reset
//     run                 level run enable, sampled at instruction boundaries
//     step                (SUBNEG_STEP_EN only) run one instruction from IDLE
//     load_valid/ready    program write handshake, ready only in IDLE
//     load_addr/data      program write address / data
//     in_data             value returned for reads of IN_ADDR
//     out_data/out_valid  last OUT_ADDR write / one-cycle update pulse
//     halted, pc          HALT indication, program counter
//
//   state | meaning
//   IDLE  | stopped, loads accepted, waits for run (or step)
//   FETCH | latch operand addresses A/B/C from mem[pc..pc+2]
//   READ  | latch valA/valB
//   EXEC  | write result, update pc, decide next state
//   HALT  | terminal until reset
module subneg_core_param
  import subneg_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int OUT_ADDR   = DEF_OUT_ADDR,
  parameter int IN_ADDR    = DEF_IN_ADDR,
  parameter int SIGNED_CMP = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
`ifdef SUBNEG_STEP_EN
  input  logic              step,
`endif
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] L_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] L_TWO   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] L_THREE = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] L_OUT   = ADDR_W'(OUT_ADDR);
  localparam logic [ADDR_W-1:0] L_IN    = ADDR_W'(IN_ADDR);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, r_addr_a, r_addr_b, r_addr_c;
  logic [DATA_W-1:0] r_val_a, r_val_b, r_out_data;
  logic              r_out_valid;
  logic              r_step_once;

  logic [ADDR_W-1:0] w_rd_addr0, w_rd_addr1, w_rd_addr2;
  logic [DATA_W-1:0] w_rd_data0, w_rd_data1, w_rd_data2;
  logic              w_we;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_res;
  logic              w_taken, w_fetch_end, w_step;

`ifdef SUBNEG_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b0;
`endif

  // FETCH uses all three ports for the instruction words; READ reuses two
  // of them for the operands.
  assign w_rd_addr0 = (r_state == ST_FETCH) ? r_pc         : r_addr_a;
  assign w_rd_addr1 = (r_state == ST_FETCH) ? r_pc + L_ONE : r_addr_b;
  assign w_rd_addr2 = r_pc + L_TWO;

  subneg_mem #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_rd_addr0(w_rd_addr0),
    .i_rd_addr1(w_rd_addr1),
    .i_rd_addr2(w_rd_addr2),
    .o_rd_data0(w_rd_data0),
    .o_rd_data1(w_rd_data1),
    .o_rd_data2(w_rd_data2),
    .i_we      (w_we),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data)
  );

  assign w_fetch_end = (int'(r_pc) + 2) >= MEM_DEPTH;
  assign w_res       = r_val_b - r_val_a;
  assign w_taken     = branch_taken(SIGNED_CMP != 0, r_val_a > r_val_b, w_res[DATA_W-1]);

  // Single write port: loader while IDLE, EXEC result otherwise.
  always_comb begin
    w_we      = 1'b0;
    w_wr_addr = load_addr;
    w_wr_data = load_data;
    if (r_state == ST_IDLE) begin
      w_we = load_valid;
    end else if (r_state == ST_EXEC) begin
      w_we      = (r_addr_b != L_OUT);
      w_wr_addr = r_addr_b;
      w_wr_data = w_res;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (run || w_step) w_state_nxt = ST_FETCH;
      ST_FETCH: w_state_nxt = w_fetch_end ? ST_HALT : ST_READ;
      ST_READ:  w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (w_taken && (r_addr_c == r_pc)) w_state_nxt = ST_HALT;
        else if (run && !r_step_once)      w_state_nxt = ST_FETCH;
        else                               w_state_nxt = ST_IDLE;
      end
      ST_HALT:  w_state_nxt = ST_HALT;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pc        <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_addr_c    <= '0;
      r_val_a     <= '0;
      r_val_b     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_step_once <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= 1'b0;
      case (r_state)
        // A step only counts when run is low; run keeps priority otherwise.
        ST_IDLE:  r_step_once <= w_step && !run;
        ST_FETCH: begin
          r_addr_a <= w_rd_data0[ADDR_W-1:0];
          r_addr_b <= w_rd_data1[ADDR_W-1:0];
          r_addr_c <= w_rd_data2[ADDR_W-1:0];
        end
        ST_READ: begin
          r_val_a <= (r_addr_a == L_IN) ? in_data : w_rd_data0;
          r_val_b <= (r_addr_b == L_IN) ? in_data : w_rd_data1;
        end
        ST_EXEC: begin
          r_pc <= w_taken ? r_addr_c : r_pc + L_THREE;
          if (r_addr_b == L_OUT) begin
            r_out_data  <= w_res;
            r_out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_ready = (r_state == ST_IDLE);
  assign halted     = (r_state == ST_HALT);
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign pc         = r_pc;

endmodule

// File: tb/tb_subneg_core_param.sv
module tb_subneg_core_param;

  logic       clk = 1'b0;
  logic       rst_n, run, load_valid;
  logic [5:0] load_addr;
  logic [7:0] load_data, in_data;
`ifdef SUBNEG_STEP_EN
  logic       step;
`endif
  logic       load_ready, out_valid, halted;
  logic [7:0] out_data;
  logic [5:0] pc;
  logic       load_ready_s, out_valid_s, halted_s;
  logic [7:0] out_data_s;
  logic [5:0] pc_s;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  subneg_core_param #(.SIGNED_CMP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef SUBNEG_STEP_EN
    .step(step),
`endif
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .in_data(in_data), .out_data(out_data),
    .out_valid(out_valid), .halted(halted), .pc(pc)
  );

  subneg_core_param #(.SIGNED_CMP(1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .run(run),
`ifdef SUBNEG_STEP_EN
    .step(step),
`endif
    .load_valid(load_valid), .load_ready(load_ready_s), .load_addr(load_addr),
    .load_data(load_data), .in_data(in_data), .out_data(out_data_s),
    .out_valid(out_valid_s), .halted(halted_s), .pc(pc_s)
  );

  typedef struct {
    int va;
    int vb;
    int exp_res;
    int exp_pc_u;
    int exp_pc_s;
  } vec_t;

  vec_t vecs[8];

  // reference model state for the randomized run
  int m[48];
  int mpc, exp_out, in_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mem_u(input int i);
    return u_dut.u_mem.r_mem[i];
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    load_valid = 1'b0;
`ifdef SUBNEG_STEP_EN
    step = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic load(input int a, input int d);
    load_valid = 1'b1;
    load_addr = 6'(a);
    load_data = 8'(d);
    tick();
    load_valid = 1'b0;
  endtask

  // one instruction from IDLE with run dropped during READ
  task automatic run_one();
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    tick();
    tick();
  endtask

  function automatic int rdm(input int x);
    if (x == 62) return in_val;
    if (x < 48) return m[x];
    return 0;
  endfunction

  initial begin
    int a, b, c, va, vb, res, mhalt;
    bit taken;
    load_addr = '0;
    load_data = '0;
    in_data = '0;
    in_val = 0;
    vecs[0] = '{5, 7, 2, 3, 3};
    vecs[1] = '{7, 5, 254, 6, 6};
    vecs[2] = '{255, 1, 2, 6, 3};
    vecs[3] = '{1, 129, 128, 3, 6};
    vecs[4] = '{128, 128, 0, 3, 3};
    vecs[5] = '{0, 0, 0, 3, 3};
    vecs[6] = '{128, 0, 128, 6, 6};
    vecs[7] = '{1, 128, 127, 3, 3};

    do_reset();
    chk("rst_pc", pc, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_load_ready", load_ready, 1);

    // directed scenario from the description: {9,10,3}, mem[9]=5, mem[10]=7
    load(0, 9); load(1, 10); load(2, 3);
    load(9, 5); load(10, 7);
    load(3, 0); load(4, 0); load(5, 3);
    run_one();
    chk("t1_pc", pc, 3);
    chk("t1_mem10", mem_u(10), 2);
    chk("t1_idle_after_run_drop", load_ready, 1);

    // branch-condition table, both comparison modes
    foreach (vecs[k]) begin
      do_reset();
      load(0, 9); load(1, 10); load(2, 6);
      load(9, vecs[k].va); load(10, vecs[k].vb);
      run_one();
      chk($sformatf("vec%0d_pc_unsigned", k), pc, vecs[k].exp_pc_u);
      chk($sformatf("vec%0d_pc_signed", k), pc_s, vecs[k].exp_pc_s);
      chk($sformatf("vec%0d_res", k), mem_u(10), vecs[k].exp_res);
    end

    // output port write
    do_reset();
    load(0, 11); load(1, 63); load(2, 3); load(11, 8'hD6);
    chk("t3_out_valid_before", out_valid, 0);
    run_one();
    chk("t3_out_data", out_data, 8'h2A);
    chk("t3_out_valid_pulse", out_valid, 1);
    tick();
    chk("t3_out_valid_drop", out_valid, 0);
    chk("t3_out_data_hold", out_data, 8'h2A);

    // jump-to-self halt, then loads ignored
    do_reset();
    load(0, 12); load(1, 13); load(2, 6);
    load(6, 9); load(7, 10); load(8, 6);
    load(9, 1); load(10, 0); load(12, 1); load(13, 0); load(20, 8'h11);
    run = 1'b1;
    repeat (4) tick();
    chk("t4_pc_at_6", pc, 6);
    tick();
    tick();
    chk("t4_not_halted_in_exec", halted, 0);
    tick();
    chk("t4_halted", halted, 1);
    chk("t4_halted_signed", halted_s, 1);
    chk("t4_pc", pc, 6);
    chk("t4_mem10", mem_u(10), 8'hFF);
    chk("t4_load_ready", load_ready, 0);
    load(20, 8'h55);
    chk("t4_load_ignored", mem_u(20), 8'h11);
    repeat (3) tick();
    chk("t4_stays_halted", halted, 1);
    run = 1'b0;

    // async reset in EXEC; memory survives
    do_reset();
    load(0, 14); load(1, 15); load(2, 3);
    load(3, 16); load(4, 63); load(5, 6);
    load(6, 14); load(7, 15); load(8, 9);
    load(14, 1); load(15, 9); load(16, 1);
    run = 1'b1;
    repeat (9) tick();
    chk("t5_out_before_reset", out_data, 8'hFF);
    chk("t5_pc_before_reset", pc, 6);
    rst_n = 1'b0;
    #1;
    chk("t5_async_pc", pc, 0);
    chk("t5_async_out", out_data, 0);
    chk("t5_async_idle", load_ready, 1);
    tick();
    tick();
    chk("t5_mem_kept", mem_u(15), 8);
    rst_n = 1'b1;
    run = 1'b0;

    // fetch past the end of memory
    do_reset();
    load(0, 14); load(1, 15); load(2, 46);
    load(14, 1); load(15, 0);
    load(46, 20); load(47, 21); load(21, 8'h33);
    run = 1'b1;
    repeat (4) tick();
    chk("t6_pc46", pc, 46);
    chk("t6_not_halted", halted, 0);
    tick();
    chk("t6_halted", halted, 1);
    chk("t6_no_write", mem_u(21), 8'h33);
    chk("t6_prev_write", mem_u(15), 8'hFF);
    chk("t6_pc_hold", pc, 46);
    run = 1'b0;

`ifdef SUBNEG_STEP_EN
    do_reset();
    load(0, 14); load(1, 15); load(2, 3);
    load(14, 1); load(15, 9);
    step = 1'b1;
    tick();
    step = 1'b0;
    repeat (6) tick();
    chk("step_pc", pc, 3);
    chk("step_idle", load_ready, 1);
    chk("step_mem", mem_u(15), 8);
`endif

    // randomized programs against an instruction-level model
    for (int it = 0; it < 8; it++) begin
      do_reset();
      exp_out = 0;
      in_val = int'($urandom_range(0, 255));
      in_data = 8'(in_val);
      for (int j = 0; j < 48; j++) begin
        m[j] = ($urandom % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 63));
        load(j, m[j]);
      end
      mpc = 0;
      run = 1'b1;
      tick();
      for (int i = 0; i < 25; i++) begin
        if (mpc + 2 >= 48) begin
          tick();
          chk("rnd_fetch_halt", halted, 1);
          chk("rnd_fetch_halt_pc", pc, 32'(mpc));
          break;
        end
        a = m[mpc] % 64;
        b = m[mpc + 1] % 64;
        c = m[mpc + 2] % 64;
        va = rdm(a);
        vb = rdm(b);
        res = (vb - va + 256) % 256;
        taken = va > vb;
        if (b == 63) exp_out = res;
        else if (b < 48) m[b] = res;
        mhalt = (taken && c == mpc) ? 1 : 0;
        mpc = taken ? c : (mpc + 3) % 64;
        tick();
        if (i == 24) run = 1'b0;
        tick();
        tick();
        chk("rnd_pc", pc, 32'(mpc));
        chk("rnd_out_valid", out_valid, (b == 63) ? 1 : 0);
        chk("rnd_out_data", out_data, 32'(exp_out));
        chk("rnd_halted", halted, 32'(mhalt));
        if (mhalt != 0) break;
      end
      run = 1'b0;
      for (int j = 0; j < 48; j++) chk($sformatf("rnd_mem%0d", j), mem_u(j), 32'(m[j]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
